demux_32_8_reg: RTL and testbench

Registered 1-to-8 write-side steering block for 32-bit data: accepts a write (selector, data, byte enables) over a valid/ready handshake, buffers it one stage, and commits it into one of eight 32-bit holding registers. The eight registers drive the eight inputs of the existing 8-way 32-bit read selector, forming the write end of the processor's 8-entry bank. A pipeline stall input freezes commits without losing the buffered write.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_32_8_reg_dec_3_8.sv | 18 +
 rtl/demux_32_8_reg.sv | 112 +++++++++++
 tb/tb_demux_32_8_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared sizes and buffer entry type for the 8-entry write steering block
package demux_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREG      = 8;
  localparam int SEL_W     = 3;
  localparam int BE_W      = WIDTH_DEF / 8;

  // One buffered write at the default data width
  typedef struct packed {
    logic [SEL_W-1:0]     sel;
    logic [WIDTH_DEF-1:0] data;
    logic [BE_W-1:0]      be;
    logic                 valid;
  } buf_entry_t;

endpackage

// File: rtl/demux_32_8_reg_dec_3_8.sv
// rtl/demux_32_8_reg_dec_3_8.sv - 3-to-8 one-hot decoder with enable (module dec_3_8)
module dec_3_8
  import demux_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NREG-1:0]  onehot
);

  // Raise exactly one line when enabled, none otherwise
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_32_8_reg.sv
// rtl/demux_32_8_reg.sv - buffered 1-to-8 byte-masked register write steering; REG0_ZERO_EN pins register 0 to zero
module demux_32_8_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               stall,
  output logic               busy,
  output logic [WIDTH-1:0]   out0,
  output logic [WIDTH-1:0]   out1,
  output logic [WIDTH-1:0]   out2,
  output logic [WIDTH-1:0]   out3,
  output logic [WIDTH-1:0]   out4,
  output logic [WIDTH-1:0]   out5,
  output logic [WIDTH-1:0]   out6,
  output logic [WIDTH-1:0]   out7
);

  localparam int BE_N = WIDTH / 8;

  // Buffer entry sized by this instance's data width
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic [BE_N-1:0]  be;
    logic             valid;
  } entry_t;

  entry_t           buf_q, buf_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  commit_onehot;
  logic             commit;
  logic             xfer;

  // A buffered write leaves whenever stall is low, so a new one can enter in that same cycle
  assign commit   = buf_q.valid && !stall;
  assign wr_ready = !buf_q.valid || !stall;
  assign xfer     = wr_valid && wr_ready;
  assign busy     = buf_q.valid;

  dec_3_8 u_dec (
    .en     (commit),
    .sel    (buf_q.sel),
    .onehot (commit_onehot)
  );

  // Load on transfer, otherwise drain on commit, otherwise hold
  always_comb begin
    buf_d = buf_q;
    if (xfer) begin
      buf_d.sel   = wr_sel;
      buf_d.data  = wr_data;
      buf_d.be    = wr_be;
      buf_d.valid = 1'b1;
    end else if (commit) begin
      buf_d.valid = 1'b0;
    end
  end

  // Merge enabled bytes of the committing write into its selected register
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      for (int b = 0; b < BE_N; b++) begin
        if (commit_onehot[r] && buf_q.be[b]) begin
          regs_d[r][8*b +: 8] = buf_q.data[8*b +: 8];
        end
      end
    end
`ifdef REG0_ZERO_EN
    regs_d[0] = '0;
`endif
  end

  // Buffer and holding registers; reset drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      buf_q <= buf_d;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

`ifdef REG0_ZERO_EN
  assign out0 = '0;
`else
  assign out0 = regs_q[0];
`endif
  assign out1 = regs_q[1];
  assign out2 = regs_q[2];
  assign out3 = regs_q[3];
  assign out4 = regs_q[4];
  assign out5 = regs_q[5];
  assign out6 = regs_q[6];
  assign out7 = regs_q[7];

endmodule

// File: tb/tb_demux_32_8_reg.sv
// tb/tb_demux_32_8_reg.sv - randomized self-checking bench for demux_32_8_reg against a queue model
module tb_demux_32_8_reg;
  import demux_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        stall;
  logic        busy;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [31:0] outs [8];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [8];
  buf_entry_t  m_q [$];

  always #5 clk = ~clk;

  demux_32_8_reg dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .stall    (stall),
    .busy     (busy),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out5     (out5),
    .out6     (out6),
    .out7     (out7)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  function automatic bit reg0_zero();
`ifdef REG0_ZERO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ready();
    return (m_q.size() == 0) || !stall;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_edge();
    bit         accept;
    buf_entry_t e;
    accept = wr_valid && exp_ready();
    if (reset) begin
      m_q.delete();
      for (int r = 0; r < 8; r++) m_regs[r] = '0;
      return;
    end
    if (m_q.size() != 0 && !stall) begin
      e = m_q.pop_front();
      if (!(reg0_zero() && e.sel == 3'd0)) begin
        m_regs[e.sel] = byte_merge(m_regs[e.sel], e.data, e.be);
      end
    end
    if (accept) begin
      e.sel   = wr_sel;
      e.data  = wr_data;
      e.be    = wr_be;
      e.valid = 1'b1;
      m_q.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq($sformatf("%s:wr_ready", tag), {31'd0, wr_ready}, {31'd0, exp_ready()});
    check_eq($sformatf("%s:busy", tag), {31'd0, busy}, {31'd0, m_q.size() != 0});
    for (int r = 0; r < 8; r++) begin
      check_eq($sformatf("%s:out%0d", tag, r), outs[r], m_regs[r]);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then let the edge happen
  task automatic cycle(input string tag, input logic rst, input logic v, input logic [2:0] sel,
                       input logic [31:0] data, input logic [3:0] be, input logic st);
    reset    = rst;
    wr_valid = v;
    wr_sel   = sel;
    wr_data  = data;
    wr_be    = be;
    stall    = st;
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) m_regs[r] = '0;
    reset = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; wr_be = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset");

    // Single full write
    cycle("single_acc", 1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    check_eq("single_pre", out5, 32'h0);
    idle("single_idle");
    check_eq("single_out5", out5, 32'hDEADBEEF);

    // Byte mask merge
    cycle("mask_a", 1'b0, 1'b1, 3'd2, 32'h11223344, 4'hF, 1'b0);
    cycle("mask_b", 1'b0, 1'b1, 3'd2, 32'hAABBCCDD, 4'b0101, 1'b0);
    idle("mask_idle");
    check_eq("mask_out2", out2, 32'h11BB33DD);

    // Stall with back-to-back writes to the same register
    cycle("stall_a", 1'b0, 1'b1, 3'd1, 32'h1, 4'hF, 1'b1);
    cycle("stall_b_held", 1'b0, 1'b1, 3'd1, 32'h2, 4'hF, 1'b1);
    check_eq("stall_out1_hold", out1, 32'h0);
    check_eq("stall_busy", {31'd0, busy}, 32'd1);
    cycle("stall_release", 1'b0, 1'b1, 3'd1, 32'h2, 4'hF, 1'b0);
    check_eq("stall_out1_a", out1, 32'h1);
    idle("stall_idle");
    check_eq("stall_out1_b", out1, 32'h2);

    // Reset while a write is buffered
    cycle("rst_acc", 1'b0, 1'b1, 3'd3, 32'hCAFE0000, 4'hF, 1'b1);
    cycle("rst_pulse", 1'b1, 1'b1, 3'd4, 32'h12345678, 4'hF, 1'b0);
    idle("rst_idle1");
    idle("rst_idle2");
    check_eq("rst_out3", out3, 32'h0);
    check_eq("rst_out4", out4, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);

    // Register 0 write
    cycle("r0_acc", 1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
    check_eq("r0_busy", {31'd0, busy}, 32'd1);
    idle("r0_idle");
    check_eq("r0_out0", out0, reg0_zero() ? 32'h0 : 32'hFFFFFFFF);

    // Zero byte enable occupies the buffer but changes nothing
    cycle("be0_acc", 1'b0, 1'b1, 3'd6, 32'h55555555, 4'h0, 1'b0);
    idle("be0_idle");
    check_eq("be0_out6", out6, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($sformatf("rnd%0d", i),
            ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            32'($urandom),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0));
    end
    idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
